// File: rtl/tl_acquire_unit.sv
// tl_acquire_unit: TileLink-C client acquire sequencer, one line refill at a time.
// Issues Acquire on A, collects Grant/GrantData on D, refills the data array, acks on E.
module tl_acquire_unit #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 128,
   parameter int SOURCE_W   = 3,
   parameter int SINK_W     = 4,
   parameter int SIZE_W     = 4,
   parameter int SOURCE_ID  = 0,
   parameter int LINE_BYTES = 64
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [1:0]            req_grow,
   input  logic                  req_perm,
   output logic                  a_valid,
   input  logic                  a_ready,
   output logic [2:0]            a_opcode,
   output logic [2:0]            a_param,
   output logic [SIZE_W-1:0]     a_size,
   output logic [SOURCE_W-1:0]   a_source,
   output logic [ADDR_W-1:0]     a_address,
   output logic [DATA_W/8-1:0]   a_mask,
   output logic [DATA_W-1:0]     a_data,
   output logic                  a_corrupt,
   input  logic                  d_valid,
   output logic                  d_ready,
   input  logic [2:0]            d_opcode,
   input  logic [1:0]            d_param,
   input  logic [SIZE_W-1:0]     d_size,
   input  logic [SOURCE_W-1:0]   d_source,
   input  logic [SINK_W-1:0]     d_sink,
   input  logic                  d_denied,
   input  logic                  d_corrupt,
   input  logic [DATA_W-1:0]     d_data,
   output logic                  e_valid,
   input  logic                  e_ready,
   output logic [SINK_W-1:0]     e_sink,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_data,
   output logic [1:0]            rsp_beat,
   output logic                  rsp_last,
   output logic                  done_valid,
   output logic [1:0]            done_cap,
   output logic                  done_denied,
   output logic                  done_error,
   output logic                  busy
);
   localparam int OFF   = $clog2(LINE_BYTES);
   localparam int BEATS = LINE_BYTES * 8 / DATA_W;
   typedef enum logic [1:0] {IDLE, ACQ, GRANT, ACK} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] addr;
   logic [SINK_W-1:0] sink;
   logic [1:0] grow, prm, cnt;
   logic perm, got, den, err;
   logic hit, is_data, last, d_fire;
   logic unused_ok;
   assign unused_ok = ^{d_size, req_addr[OFF-1:0]};
   assign hit = d_source == SOURCE_W'(SOURCE_ID) && (d_opcode == 3'd4 || d_opcode == 3'd5);
   assign is_data = d_opcode == 3'd5;
   // a Grant arriving mid-burst also closes the transaction
   assign last = !is_data || cnt == 2'(BEATS - 1);
   assign d_fire = d_valid && d_ready;
   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      a_valid   = 1'b0;
      d_ready   = 1'b0;
      e_valid   = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nx = ACQ;
         end
         ACQ: begin
            a_valid = 1'b1;
            if (a_ready) state_nx = GRANT;
         end
         GRANT: begin
            d_ready = 1'b1;
            if (d_valid && hit && last) state_nx = ACK;
         end
         ACK: begin
            e_valid = 1'b1;
            if (e_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   assign a_opcode  = a_valid ? (perm ? 3'd7 : 3'd6) : 3'd0;
   assign a_param   = a_valid ? {1'b0, grow} : 3'd0;
   assign a_size    = a_valid ? SIZE_W'(OFF) : '0;
   assign a_source  = a_valid ? SOURCE_W'(SOURCE_ID) : '0;
   assign a_address = a_valid ? addr : '0;
   assign a_mask    = {(DATA_W/8){a_valid}};
   assign a_data    = '0;
   assign a_corrupt = 1'b0;
   assign e_sink    = e_valid ? sink : '0;
   assign busy      = state != IDLE;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr        <= '0;
         sink        <= '0;
         grow        <= '0;
         prm         <= '0;
         cnt         <= '0;
         perm        <= 1'b0;
         got         <= 1'b0;
         den         <= 1'b0;
         err         <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_beat    <= '0;
         rsp_last    <= 1'b0;
         done_valid  <= 1'b0;
         done_cap    <= '0;
         done_denied <= 1'b0;
         done_error  <= 1'b0;
      end else begin
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_beat    <= '0;
         rsp_last    <= 1'b0;
         done_valid  <= 1'b0;
         done_cap    <= '0;
         done_denied <= 1'b0;
         done_error  <= 1'b0;
         if (req_valid && req_ready) begin
            addr <= {req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
            grow <= req_grow;
            perm <= req_perm;
            sink <= '0;
            prm  <= '0;
            cnt  <= '0;
            got  <= 1'b0;
            den  <= 1'b0;
            err  <= 1'b0;
         end
         if (d_fire && !hit) err <= 1'b1;
         if (d_fire && hit) begin
            got <= 1'b1;
            if (!got) begin
               sink <= d_sink;
               prm  <= d_param;
            end
            den <= den | d_denied;
            // dataless Grant is wrong mid-burst and wrong as the answer to AcquireBlock
            if (d_corrupt || (!is_data && (cnt != 2'd0 || !perm))) err <= 1'b1;
            cnt <= is_data ? cnt + 2'd1 : 2'd0;
            if (is_data) begin
               rsp_valid <= 1'b1;
               rsp_data  <= d_data;
               rsp_beat  <= cnt;
               rsp_last  <= last;
            end
         end
         if (e_valid && e_ready) begin
            done_valid  <= 1'b1;
            done_cap    <= prm == 2'd0 ? 2'd2 : prm == 2'd1 ? 2'd1 : 2'd0;
            done_denied <= den;
            done_error  <= err | (prm == 2'd3);
         end
      end
   end
endmodule

// File: tb/tb_tl_acquire_unit.sv
// tb_tl_acquire_unit: random and directed acquire transactions checked against a
// transaction-level model of the expected A request, refill beats, E ack and completion.
module tb_tl_acquire_unit;
   logic clock = 0, reset_n = 0;
   logic req_valid = 0, req_ready, req_perm = 0;
   logic [31:0] req_addr = 0;
   logic [1:0] req_grow = 0;
   logic a_valid, a_ready = 0, a_corrupt;
   logic [2:0] a_opcode, a_param;
   logic [3:0] a_size;
   logic [2:0] a_source;
   logic [31:0] a_address;
   logic [15:0] a_mask;
   logic [127:0] a_data;
   logic d_valid = 0, d_ready, d_denied = 0, d_corrupt = 0;
   logic [2:0] d_opcode = 0, d_source = 0;
   logic [1:0] d_param = 0;
   logic [3:0] d_size = 0, d_sink = 0;
   logic [127:0] d_data = 0;
   logic e_valid, e_ready = 0;
   logic [3:0] e_sink;
   logic rsp_valid, rsp_last, done_valid, done_denied, done_error, busy;
   logic [127:0] rsp_data;
   logic [1:0] rsp_beat, done_cap;

   tl_acquire_unit dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_grow(req_grow), .req_perm(req_perm),
      .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
      .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt),
      .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
      .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied), .d_corrupt(d_corrupt), .d_data(d_data),
      .e_valid(e_valid), .e_ready(e_ready), .e_sink(e_sink),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_beat(rsp_beat), .rsp_last(rsp_last),
      .done_valid(done_valid), .done_cap(done_cap), .done_denied(done_denied), .done_error(done_error),
      .busy(busy)
   );

   initial forever #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr; logic [2:0] op; logic [2:0] par; int n; logic [15:0] gives;
      logic [3:0] sink; logic [1:0] cap; logic den; logic err;
   } txn_t;
   typedef struct { logic [127:0] data; logic [1:0] beat; logic last; } rsp_t;
   txn_t exp_q[$];
   rsp_t rsp_q[$];
   txn_t model;
   int checks = 0, errors = 0, cyc = 0;
   int rdy_pct = 100, a_hold = 0, e_hold = 0, d_gap = 0;
   logic [2:0] b_op[16], b_src[16];
   logic [1:0] b_prm[16];
   logic [3:0] b_sink[16];
   logic b_den[16], b_cor[16];
   logic [127:0] b_dat[16];
   int nb = 0;
   int req_cyc = 0, done_cyc = 0, rsp_seen = 0, a_cycles = 0, e_cycles = 0;
   logic [31:0] seen_addr = 0;
   logic [2:0] seen_op = 0, seen_par = 0;
   logic [3:0] seen_size = 0, seen_sink = 0;
   logic [15:0] seen_mask = 0;
   logic [1:0] seen_cap = 0, seen_lastbeat = 0;
   logic seen_den = 0, seen_err = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ready generator; holds count cycles with the channel valid
   initial forever begin
      @(posedge clock); #1;
      cyc++;
      if (a_valid && a_hold > 0) begin a_ready = 0; a_hold--; end
      else a_ready = $urandom_range(0, 99) < rdy_pct;
      if (e_valid && e_hold > 0) begin e_ready = 0; e_hold--; end
      else e_ready = $urandom_range(0, 99) < rdy_pct;
   end

   // compare process: protocol phases follow observed handshakes
   initial begin
      int phase, fidx;
      bit pend_rsp, pend_done;
      rsp_t r;
      txn_t t;
      phase = 0; fidx = 0; pend_rsp = 0; pend_done = 0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            chk("rst_req_ready", req_ready, 1);
            chk("rst_a_valid", a_valid, 0);
            chk("rst_d_ready", d_ready, 0);
            chk("rst_e_valid", e_valid, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_last", rsp_last, 0);
            chk("rst_rsp_beat", rsp_beat, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_done_valid", done_valid, 0);
            chk("rst_done_cap", done_cap, 0);
            chk("rst_busy", busy, 0);
            chk("rst_a_address", a_address, 0);
            chk("rst_a_opcode", a_opcode, 0);
            chk("rst_e_sink", e_sink, 0);
            phase = 0; fidx = 0; pend_rsp = 0; pend_done = 0;
            exp_q.delete(); rsp_q.delete();
         end else begin
            chk("req_ready", req_ready, phase == 0);
            chk("a_valid", a_valid, phase == 1);
            chk("d_ready", d_ready, phase == 2);
            chk("e_valid", e_valid, phase == 3);
            chk("busy", busy, phase != 0);
            chk("rsp_valid", rsp_valid, pend_rsp);
            chk("done_valid", done_valid, pend_done);
            if (a_valid && exp_q.size() > 0) begin
               chk("a_opcode", a_opcode, exp_q[0].op);
               chk("a_param", a_param, exp_q[0].par);
               chk("a_address", a_address, exp_q[0].addr);
               chk("a_size", a_size, 6);
               chk("a_source", a_source, 0);
               chk("a_mask", a_mask, 16'hFFFF);
               chk("a_data", a_data, 0);
               chk("a_corrupt", a_corrupt, 0);
               seen_addr = a_address; seen_op = a_opcode; seen_par = a_param;
               seen_size = a_size; seen_mask = a_mask; a_cycles++;
            end
            if (e_valid && exp_q.size() > 0) begin
               chk("e_sink", e_sink, exp_q[0].sink);
               seen_sink = e_sink; e_cycles++;
            end
            if (rsp_valid) begin
               rsp_seen++;
               if (rsp_last) seen_lastbeat = rsp_beat;
               if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
               else begin
                  r = rsp_q.pop_front();
                  chk("rsp_data", rsp_data, r.data);
                  chk("rsp_beat", rsp_beat, r.beat);
                  chk("rsp_last", rsp_last, r.last);
               end
            end
            if (done_valid) begin
               done_cyc = cyc;
               seen_cap = done_cap; seen_den = done_denied; seen_err = done_error;
               if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
               else begin
                  t = exp_q.pop_front();
                  chk("done_cap", done_cap, t.cap);
                  chk("done_denied", done_denied, t.den);
                  chk("done_error", done_error, t.err);
               end
            end
            pend_rsp = 0; pend_done = 0;
            if (phase == 0 && req_valid && req_ready) begin
               phase = 1; req_cyc = cyc; a_cycles = 0; e_cycles = 0;
            end else if (phase == 1 && a_valid && a_ready) begin
               phase = 2; fidx = 0;
            end else if (phase == 2 && d_valid && d_ready) begin
               if (exp_q.size() > 0) begin
                  pend_rsp = exp_q[0].gives[fidx];
                  if (fidx == exp_q[0].n - 1) phase = 3;
               end
               fidx++;
            end else if (phase == 3 && e_valid && e_ready) begin
               phase = 0; pend_done = 1;
            end
         end
      end
   end

   task automatic wait_fire(input int w, output bit ok);
      ok = 0;
      for (int c = 0; c < 300 && !ok; c++) begin
         @(negedge clock);
         ok = (w == 0) ? req_ready : (w == 1) ? d_ready : (e_valid & e_ready);
         @(posedge clock); #1;
      end
      chk($sformatf("handshake_%0d_seen", w), ok, 1);
   endtask

   task automatic recover();
      reset_n = 0; req_valid = 0; d_valid = 0;
      repeat (2) begin @(posedge clock); #1; end
      reset_n = 1;
   endtask

   task automatic settle();
      repeat (2) begin @(posedge clock); #1; end
   endtask

   task automatic add_beat(input logic [2:0] op, input logic [2:0] src, input logic [1:0] prm, input logic [3:0] sink);
      b_op[nb] = op; b_src[nb] = src; b_prm[nb] = prm; b_sink[nb] = sink;
      b_den[nb] = 0; b_cor[nb] = 0;
      b_dat[nb] = {$urandom, $urandom, $urandom, $urandom};
      nb++;
   endtask

   task automatic add_foreign();
      if ($urandom_range(0, 1) == 1) add_beat(3'd5, 3'd2, 2'($urandom), 4'($urandom));
      else add_beat(3'd1, 3'd0, 2'($urandom), 4'($urandom));
   endtask

   task automatic gen_data(input logic [3:0] sink, input logic [1:0] prm, input int foreign_at, input int cut_at);
      nb = 0;
      for (int k = 0; k < 4; k++) begin
         if (k == foreign_at) add_foreign();
         if (k == cut_at) begin add_beat(3'd4, 3'd0, prm, sink); return; end
         add_beat(3'd5, 3'd0, prm, sink);
      end
   endtask

   task automatic gen_grant(input logic [3:0] sink, input logic [1:0] prm, input bit foreign);
      nb = 0;
      if (foreign) add_foreign();
      add_beat(3'd4, 3'd0, prm, sink);
   endtask

   task automatic run_txn(input logic [31:0] addr, input logic [1:0] grow, input logic perm, input int abort_at);
      txn_t t;
      rsp_t r;
      bit first, ok;
      logic [1:0] c, p;
      first = 1; c = 0; p = 0;
      t.addr = addr & 32'hFFFF_FFC0; t.op = perm ? 3'd7 : 3'd6; t.par = {1'b0, grow};
      t.n = nb; t.gives = 0; t.sink = 0; t.den = 0; t.err = 0;
      for (int i = 0; i < nb; i++) begin
         if (b_src[i] != 0 || (b_op[i] != 4 && b_op[i] != 5)) begin t.err = 1; continue; end
         if (first) begin t.sink = b_sink[i]; p = b_prm[i]; first = 0; end
         t.den |= b_den[i];
         if (b_cor[i]) t.err = 1;
         if (b_op[i] == 5) begin
            t.gives[i] = 1; r.data = b_dat[i]; r.beat = c; r.last = (c == 3);
            rsp_q.push_back(r); c++;
         end else if (c != 0 || !perm) t.err = 1;
      end
      t.cap = (p == 0) ? 2'd2 : (p == 1) ? 2'd1 : 2'd0;
      if (p == 3) t.err = 1;
      model = t;
      exp_q.push_back(t);
      req_valid = 1; req_addr = addr; req_grow = grow; req_perm = perm;
      wait_fire(0, ok);
      req_valid = 0; req_addr = $urandom; req_grow = 2'($urandom); req_perm = 1'($urandom);
      if (!ok) begin recover(); return; end
      for (int i = 0; i < nb; i++) begin
         repeat ($urandom_range(0, d_gap)) begin @(posedge clock); #1; end
         d_valid = 1; d_opcode = b_op[i]; d_source = b_src[i]; d_param = b_prm[i]; d_sink = b_sink[i];
         d_denied = b_den[i]; d_corrupt = b_cor[i]; d_data = b_dat[i]; d_size = 4'd6;
         if (i == abort_at) begin
            reset_n = 0; #1;
            chk("abort_busy", busy, 0);
            chk("abort_req_ready", req_ready, 1);
            chk("abort_a_valid", a_valid, 0);
            chk("abort_d_ready", d_ready, 0);
            chk("abort_e_valid", e_valid, 0);
            chk("abort_rsp_valid", rsp_valid, 0);
            chk("abort_rsp_data", rsp_data, 0);
            d_valid = 0;
            repeat (2) begin @(posedge clock); #1; end
            reset_n = 1;
            return;
         end
         wait_fire(1, ok);
         d_valid = 0;
         if (!ok) begin recover(); return; end
      end
      wait_fire(2, ok);
      if (!ok) recover();
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   initial begin
      int r0, kind, fa, ca;
      repeat (3) begin @(posedge clock); #1; end
      reset_n = 1;
      // AcquireBlock NtoT, back-to-back GrantData toT sink 5
      rdy_pct = 100; d_gap = 0;
      gen_data(4'd5, 2'd0, -1, -1);
      r0 = rsp_seen;
      run_txn(32'h8000_0047, 2'd1, 1'b0, -1);
      settle();
      chk("t1_model_cap", model.cap, 2);
      chk("t1_addr", seen_addr, 32'h8000_0040);
      chk("t1_opcode", seen_op, 6);
      chk("t1_param", seen_par, 1);
      chk("t1_size", seen_size, 6);
      chk("t1_mask", seen_mask, 16'hFFFF);
      chk("t1_e_sink", seen_sink, 5);
      chk("t1_done_cap", seen_cap, 2);
      chk("t1_done_denied", seen_den, 0);
      chk("t1_done_error", seen_err, 0);
      chk("t1_rsp_count", rsp_seen - r0, 4);
      chk("t1_last_beat", seen_lastbeat, 3);
      chk("t1_done_latency", done_cyc - req_cyc, 7);
      // AcquirePerm BtoT, single Grant toT sink 9
      gen_grant(4'd9, 2'd0, 0);
      r0 = rsp_seen;
      run_txn(32'h1234_5678, 2'd2, 1'b1, -1);
      settle();
      chk("t2_opcode", seen_op, 7);
      chk("t2_e_sink", seen_sink, 9);
      chk("t2_done_cap", seen_cap, 2);
      chk("t2_done_error", seen_err, 0);
      chk("t2_rsp_count", rsp_seen - r0, 0);
      // stalled A and E
      gen_data(4'd3, 2'd1, -1, -1);
      a_hold = 5; e_hold = 3;
      run_txn(32'h0000_1000, 2'd0, 1'b0, -1);
      settle();
      chk("t3_a_cycles", a_cycles, 6);
      chk("t3_e_cycles", e_cycles, 4);
      chk("t3_done_cap", seen_cap, 1);
      // foreign beat interleaved, denied on data beat 1
      gen_data(4'd5, 2'd0, 1, -1);
      b_den[2] = 1;
      r0 = rsp_seen;
      run_txn(32'h0000_2040, 2'd1, 1'b0, -1);
      settle();
      chk("t4_rsp_count", rsp_seen - r0, 4);
      chk("t4_last_beat", seen_lastbeat, 3);
      chk("t4_done_error", seen_err, 1);
      chk("t4_done_denied", seen_den, 1);
      // cap mapping toB and invalid param
      gen_data(4'd4, 2'd1, -1, -1);
      run_txn(32'h0000_3000, 2'd0, 1'b0, -1);
      settle();
      chk("t5_tob_cap", seen_cap, 1);
      chk("t5_tob_error", seen_err, 0);
      gen_data(4'd4, 2'd3, -1, -1);
      run_txn(32'h0000_3040, 2'd0, 1'b0, -1);
      settle();
      chk("t5_p3_cap", seen_cap, 0);
      chk("t5_p3_error", seen_err, 1);
      // reset while beat 2 is on D, then a clean transaction
      gen_data(4'd6, 2'd0, -1, -1);
      run_txn(32'h0000_4000, 2'd1, 1'b0, 2);
      gen_data(4'd7, 2'd0, -1, -1);
      r0 = rsp_seen;
      run_txn(32'h0000_5000, 2'd1, 1'b0, -1);
      settle();
      chk("t6_rsp_count", rsp_seen - r0, 4);
      chk("t6_e_sink", seen_sink, 7);
      chk("t6_done_error", seen_err, 0);
      // randomized traffic
      for (int n = 0; n < 60; n++) begin
         rdy_pct = $urandom_range(40, 100);
         d_gap = $urandom_range(0, 2);
         kind = $urandom_range(0, 2);
         fa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
         ca = (kind == 2) ? $urandom_range(1, 3) : -1;
         if (kind == 1) gen_grant(4'($urandom), 2'($urandom), $urandom_range(0, 3) == 0);
         else gen_data(4'($urandom), 2'($urandom_range(0, 3)), fa, ca);
         for (int i = 1; i < nb; i++) begin
            if ($urandom_range(0, 3) == 0) begin b_prm[i] = 2'($urandom); b_sink[i] = 4'($urandom); end
            b_den[i] = $urandom_range(0, 9) == 0;
            b_cor[i] = $urandom_range(0, 9) == 0;
         end
         b_den[0] = $urandom_range(0, 9) == 0;
         if ($urandom_range(0, 3) == 0) begin a_hold = $urandom_range(1, 4); e_hold = $urandom_range(1, 4); end
         run_txn($urandom, 2'($urandom_range(0, 2)), 1'($urandom), -1);
      end
      settle();
      settle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/tl_acquire_unit.md
# tl_acquire_unit

Client-side TileLink-C acquire sequencer between an L1 miss handler and the outbound TileLink link. Accepts one miss request, issues AcquireBlock or AcquirePerm on channel A, collects Grant/GrantData on channel D (128-bit beats, 64-byte line), streams refill beats to the data array, and closes the transaction with GrantAck on channel E. One transaction in flight; uses the shared BundleParam/TLMessages encodings.

## Interface

- ADDR_W, 32, address width (BundleParam addressBits)
- DATA_W, 128, beat width (dataBits)
- SOURCE_W, 3, source id width; SINK_W, 4, sink id width; SIZE_W, 4, size width
- SOURCE_ID, 0, this unit's fixed A-channel source id
- LINE_BYTES, 64, line size; BEATS = LINE_BYTES*8/DATA_W = 4; a_size = log2(LINE_BYTES) = 6

- clock  in  1  sole clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid / req_ready  in / out  1  miss request handshake
- req_addr  in  ADDR_W  miss address (low log2(LINE_BYTES) bits ignored)
- req_grow  in  2  NtoB=0, NtoT=1, BtoT=2
- req_perm  in  1  1 = AcquirePerm (7), 0 = AcquireBlock (6)
- a_valid, a_ready  out, in  1; a_opcode out 3; a_param out 3; a_size out SIZE_W; a_source out SOURCE_W; a_address out ADDR_W; a_mask out DATA_W/8; a_data out DATA_W; a_corrupt out 1
- d_valid, d_ready  in, out  1; d_opcode in 3; d_param in 2; d_size in SIZE_W; d_source in SOURCE_W; d_sink in SINK_W; d_denied in 1; d_corrupt in 1; d_data in DATA_W
- e_valid, e_ready  out, in  1; e_sink out SINK_W
- rsp_valid out 1; rsp_data out DATA_W; rsp_beat out 2; rsp_last out 1  refill beat to data array
- done_valid out 1; done_cap out 2 (Nothing=0, Branch=1, Trunk=2); done_denied out 1; done_error out 1
- busy  out  1  state != IDLE

## Operation

- States: IDLE, ACQ, GRANT, ACK.
- IDLE: req_ready=1. req fire latches aligned address (low 6 bits zeroed), grow, perm; -> ACQ.
- ACQ: a_valid=1; a_opcode=perm?7:6; a_param=grow; a_size=6; a_source=SOURCE_ID; a_mask all ones; a_data=0; a_corrupt=0. All A fields stable until a_ready. A fire -> GRANT.
- GRANT: d_ready=1. A D beat "matches" when d_source==SOURCE_ID and d_opcode is Grant(4) or GrantData(5).
  - Non-matching beat: consumed, sets sticky error, no counter change, no rsp.
  - First matching beat latches d_sink, d_param, denied; subsequent beats OR in denied, d_corrupt sets error.
  - Grant: single beat -> ACK.
  - GrantData: 2-bit beat counter from 0; each beat produces rsp; beat 3 -> ACK, counter wraps to 0.
  - Matching opcode changes mid-burst (Grant during GrantData): error set, beat treated as last -> ACK.
- ACK: e_valid=1, e_sink=latched sink; e_ready fire -> IDLE, done pulse.
- Cap mapping: d_param toT(0)->Trunk(2), toB(1)->Branch(1), toN(2)->Nothing(0); 3 -> Nothing and error.
- done_error also set if GrantData was received for req_perm=0 with d_corrupt on any beat, or Grant received for AcquireBlock (no data) - latter sets error, not denied.

## Timing

- Reset (async assert, sync deassert internally not required): state IDLE; req_ready=1; a_valid, d_ready, e_valid, rsp_valid, rsp_last, done_valid, busy = 0; rsp_beat=0; all data/field outputs 0. Reset mid-transaction aborts silently; no E is sent.
- req fire cycle N -> a_valid=1 at N+1 (earliest A fire N+1).
- A fire cycle M -> d_ready=1 from M+1.
- rsp_valid/rsp_data/rsp_beat/rsp_last registered: D fire cycle K -> rsp at K+1 for one cycle; rsp_last=1 with beat 3.
- Last D beat cycle L -> e_valid=1 at L+1; held until e_ready.
- E fire cycle P -> IDLE at P+1; done_valid=1 and done_* valid at P+1 for exactly one cycle; req_ready=1 at P+1 (back-to-back req accepted at P+1).
- Minimum transaction, all ready: req N, A N+1, D N+2..N+5, E N+6, done N+7.
- d_ready=0 outside GRANT; D traffic there is not consumed.

## Test plan

- AcquireBlock NtoT addr 0x8000_0047, all readies high, GrantData toT sink 5 four beats -> A opcode 6 param 1 size 6 addr 0x8000_0040 mask 0xFFFF; rsp beats 0..3 with rsp_last on 3; e_sink=5; done_cap=2, denied=0, error=0 at cycle N+7.
- AcquirePerm BtoT, Grant toT sink 9 single beat -> no rsp; e_sink=9; done_cap=2.
- a_ready low 5 cycles, e_ready low 3 cycles -> A/E fields stable throughout; done one cycle after E fire.
- GrantData with d_source=2 beat interleaved, then d_denied=1 on beat 1 -> foreign beat consumed, counter unchanged, done_error=1, done_denied=1.
- d_param toB -> done_cap=1; d_param 3 -> done_cap=0, done_error=1.
- reset_n low during GRANT beat 2 -> all outputs zero immediately; after release req_ready=1, next request completes normally with beat count from 0.
